// File: rtl/trackball_pkg.sv
// trackball_pkg: shared types and trakball_o bit positions for the trackball emulator
package trackball_pkg;
  typedef enum logic {IDLE, MOVE} axis_state_t;
  localparam int TB_HCLK   = 0;
  localparam int TB_HDIR   = 1;
  localparam int TB_VCLK   = 2;
  localparam int TB_VDIR   = 3;
  localparam int TB_P2_OFS = 4;
endpackage

// File: rtl/trackball_axis.sv
// trackball_axis: one trackball axis, clock/direction pair with ramped step rate
// Ports: clk, rst (async, active-high), pos_i/neg_i (active-high direction requests),
//        tick_i (one-cycle base tick), clk_o (quadrature-style step clock), dir_o (1 = pos).
module trackball_axis
  import trackball_pkg::*;
#(
  parameter int PERIOD_MAX = 40,
  parameter int PERIOD_MIN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pos_i,
  input  logic neg_i,
  input  logic tick_i,
  output logic clk_o,
  output logic dir_o
);
  localparam int W = $clog2(PERIOD_MAX + 1);
  localparam logic [W-1:0] PMAX = W'(PERIOD_MAX);
  localparam logic [W-1:0] PMIN = W'(PERIOD_MIN);
  axis_state_t state_q;
  logic [W-1:0] period_q, cnt_q;
  logic clk_q, dir_q;
  logic stop;
  // leave MOVE when the press that started the move goes away or both sides are pressed
  assign stop = !(dir_q ? pos_i : neg_i) || (pos_i && neg_i);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= PMAX;
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pos_i ^ neg_i) begin
          state_q  <= MOVE;
          dir_q    <= pos_i;
          period_q <= PMAX;
          cnt_q    <= '0;
        end
        MOVE: if (stop) state_q <= IDLE;
          else if (tick_i) begin
            if (cnt_q == '0) begin
              clk_q    <= ~clk_q;
              cnt_q    <= period_q - 1'b1;
              period_q <= (period_q > PMIN) ? period_q - 1'b1 : PMIN;
            end else cnt_q <= cnt_q - 1'b1;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign clk_o = clk_q;
  assign dir_o = dir_q;
endmodule

// File: rtl/joy_trackball_emu.sv
// joy_trackball_emu: drives Centipede trakball_i from two active-low digital joysticks
// Ports: clk_12mhz, reset (async, active-high), joy1_n/joy2_n {R,L,D,U} active-low async,
//        rotate (swap axes), trakball_o [3:0] P1 {vdir,vclk,hdir,hclk}, [7:4] P2 same order.
module joy_trackball_emu
  import trackball_pkg::*;
#(
  parameter int TICK_DIV   = 1200,
  parameter int PERIOD_MAX = 40,
  parameter int PERIOD_MIN = 4
) (
  input  logic       clk_12mhz,
  input  logic       reset,
  input  logic [3:0] joy1_n,
  input  logic [3:0] joy2_n,
  input  logic       rotate,
  output logic [7:0] trakball_o
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [7:0] s1_q, s2_q;
  logic [TW-1:0] div_q;
  logic tick;
  // synchronizers preset to released so nothing moves straight out of reset
  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= {joy2_n, joy1_n};
      s2_q <= s1_q;
    end
  end
  assign tick = (div_q == TW'(TICK_DIV - 1));
  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) div_q <= '0;
    else div_q <= tick ? '0 : div_q + 1'b1;
  end
  for (genvar p = 0; p < 2; p++) begin : g_pl
    logic r, l, d, u;
    assign {r, l, d, u} = ~s2_q[4*p +: 4];
    trackball_axis #(.PERIOD_MAX(PERIOD_MAX), .PERIOD_MIN(PERIOD_MIN)) u_h (
      .clk(clk_12mhz), .rst(reset),
      .pos_i(rotate ? u : r), .neg_i(rotate ? d : l), .tick_i(tick),
      .clk_o(trakball_o[TB_P2_OFS*p + TB_HCLK]), .dir_o(trakball_o[TB_P2_OFS*p + TB_HDIR])
    );
    trackball_axis #(.PERIOD_MAX(PERIOD_MAX), .PERIOD_MIN(PERIOD_MIN)) u_v (
      .clk(clk_12mhz), .rst(reset),
      .pos_i(rotate ? l : u), .neg_i(rotate ? r : d), .tick_i(tick),
      .clk_o(trakball_o[TB_P2_OFS*p + TB_VCLK]), .dir_o(trakball_o[TB_P2_OFS*p + TB_VDIR])
    );
  end
endmodule

// File: tb/tb_joy_trackball_emu.sv
// tb_joy_trackball_emu: self-checking bench with a step-schedule model of all four axes
module tb_joy_trackball_emu;
  localparam int TD = 4, PMAX = 5, PMIN = 2;
  logic clk = 1'b0, reset = 1'b0, rotate = 1'b0;
  logic [3:0] j1 = 4'hF, j2 = 4'hF;
  logic [7:0] tb_o;
  int errors = 0, checks = 0, cyc = 0;
  bit cmp_en = 0;
  int tq[$], dq[$];
  int t4 = 0;
  logic prev0 = 1'b0, prev1 = 1'b0, prev4 = 1'b0;
  int eg[6] = '{20, 16, 12, 8, 8, 8};

  always #5 clk = ~clk;

  joy_trackball_emu #(.TICK_DIV(TD), .PERIOD_MAX(PMAX), .PERIOD_MIN(PMIN)) dut (
    .clk_12mhz(clk), .reset(reset), .joy1_n(j1), .joy2_n(j2), .rotate(rotate), .trakball_o(tb_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // tick index (counted from entry into motion) of the k-th step toggle
  function automatic int toggle_at(input int k);
    int t;
    t = 1;
    for (int i = 0; i < k; i++) t += (PMAX - i > PMIN) ? PMAX - i : PMIN;
    return t;
  endfunction

  // model: per axis, moving/dir/clk level, ticks since entry, toggles done
  logic [7:0] m_s1, m_s2;
  int m_cyc;
  bit mv[4], md[4], mc[4];
  int mt[4], mk[4];
  logic [7:0] model_o;
  bit m_tick, pos, neg;
  logic [3:0] mj;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = '1;
      m_s2 = '1;
      m_cyc = 0;
      for (int a = 0; a < 4; a++) begin
        mv[a] = 0; md[a] = 0; mc[a] = 0; mt[a] = 0; mk[a] = 0;
      end
    end else begin
      m_tick = (m_cyc % TD) == TD - 1;
      m_cyc++;
      for (int a = 0; a < 4; a++) begin
        mj = ~m_s2[4*(a/2) +: 4];
        if (a % 2 == 0) begin
          pos = rotate ? mj[0] : mj[3];
          neg = rotate ? mj[1] : mj[2];
        end else begin
          pos = rotate ? mj[2] : mj[0];
          neg = rotate ? mj[3] : mj[1];
        end
        if (mv[a]) begin
          if ((md[a] ? !pos : !neg) || (pos && neg)) mv[a] = 0;
          else if (m_tick) begin
            mt[a]++;
            if (mt[a] == toggle_at(mk[a])) begin
              mc[a] = !mc[a];
              mk[a]++;
            end
          end
        end else if (pos != neg) begin
          mv[a] = 1; md[a] = pos; mt[a] = 0; mk[a] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {j2, j1};
    end
    model_o = {md[3], mc[3], md[2], mc[2], md[1], mc[1], md[0], mc[0]};
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmp_en) chk("trakball_o", int'(tb_o), int'(model_o));
    if (tb_o[0] !== prev0) tq.push_back(cyc);
    if (tb_o[1] !== prev1) dq.push_back(cyc);
    if (tb_o[4] !== prev4) t4++;
    prev0 = tb_o[0];
    prev1 = tb_o[1];
    prev4 = tb_o[4];
  end

  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic r, input int n);
    @(negedge clk);
    #2;
    j1 = a;
    j2 = b;
    rotate = r;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    j1 = 4'hF;
    j2 = 4'hF;
    rotate = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset_async", int'(tb_o), 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic chk_gaps(input string nm, input int start, input int n);
    if (tq.size() < start + n + 1) chk({nm, "_count"}, tq.size(), start + n + 1);
    else for (int i = 0; i < n; i++) chk(nm, tq[start+i+1] - tq[start+i], eg[i]);
  endtask

  int n0, f;
  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out", int'(tb_o), 0);
    chk("sched_t1", toggle_at(0), 1);
    chk("sched_t6", toggle_at(1), 6);
    chk("sched_t19", toggle_at(6), 19);
    #1;
    reset = 1'b0;
    cmp_en = 1;
    // hold R
    tq.delete();
    step(4'b0111, 4'hF, 1'b0, 130);
    chk("hold_r_hdir", int'(tb_o[1]), 1);
    chk("hold_r_others", int'(tb_o[7:2]), 0);
    chk_gaps("hold_r_gap", 0, 6);
    // hold L then release
    step(4'hF, 4'hF, 1'b0, 10);
    tq.delete();
    step(4'b1011, 4'hF, 1'b0, 130);
    chk("hold_l_hdir", int'(tb_o[1]), 0);
    chk_gaps("hold_l_gap", 0, 6);
    step(4'hF, 4'hF, 1'b0, 4);
    n0 = tq.size();
    repeat (40) @(negedge clk);
    chk("release_stops", tq.size(), n0);
    // both R and L pressed, then release L
    tq.delete();
    step(4'b0011, 4'hF, 1'b0, 200);
    chk("both_no_motion", tq.size(), 0);
    step(4'b0111, 4'hF, 1'b0, 60);
    chk_gaps("restart_gap", 0, 1);
    // rotated P2 up
    do_reset();
    t4 = 0;
    step(4'hF, 4'b1110, 1'b1, 120);
    chk("rot_p2_moves", int'(t4 > 0), 1);
    chk("rot_p2_hdir", int'(tb_o[5]), 1);
    chk("rot_p2_v", int'(tb_o[7:6]), 0);
    chk("rot_p1", int'(tb_o[3:0]), 0);
    // reversal at max speed (reset lands mid-move)
    do_reset();
    tq.delete();
    step(4'b0111, 4'hF, 1'b0, 100);
    dq.delete();
    step(4'b1011, 4'hF, 1'b0, 80);
    chk("rev_dir_edges", dq.size(), 1);
    chk("rev_hdir", int'(tb_o[1]), 0);
    f = -1;
    if (dq.size() > 0)
      foreach (tq[i]) begin
        if (tq[i] == dq[0]) chk("rev_same_edge", tq[i], -1);
        if (f < 0 && tq[i] > dq[0]) f = i;
      end
    chk("rev_found", int'(f >= 0), 1);
    if (f >= 0) chk_gaps("rev_gap", f, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
